// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 set-2 keycode decoder.
//   ps2_state_t : decoder FSM states (idle, after E0, after F0, after E0 F0)
//   SC_*        : scan-code bytes the decoder recognises
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } ps2_state_t;

  localparam logic [7:0] SC_E0    = 8'hE0;  // extended prefix
  localparam logic [7:0] SC_F0    = 8'hF0;  // break (release) prefix
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_UP    = 8'h75;  // E0-prefixed
  localparam logic [7:0] SC_DOWN  = 8'h72;  // E0-prefixed
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_NUL   = 8'h00;  // keyboard error / overrun
  localparam logic [7:0] SC_ERR   = 8'hFF;  // keyboard error / overrun

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_E0) || (b == SC_F0);
  endfunction

endpackage

// File: rtl/ps2_keycode_decoder.sv
// PS/2 set-2 scan-code decoder with a small game key map.
// Turns the byte stream from a PS/2 receiver into press/release events and
// held-key levels, flagging illegal sequences and stalled prefixes.
//   clk, rst_n          : system clock (rising edge), async active-low reset
//   key_valid, key_data : one-cycle strobe + byte from the PS/2 receiver
//   evt_valid           : one-cycle strobe, decoded key event
//   evt_code/ext/break  : final byte, E0 flag, release flag (held until next event)
//   p1_up .. start_key  : held-key levels (W, S, Up, Down, Space)
//   proto_err           : one-cycle strobe, illegal sequence or prefix timeout
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic       start_key,
  output logic       proto_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             armed_reg;
  logic             kv;
  logic             emit, emit_ext, emit_brk, err_next;

  // armed_reg stays low for the first edge after reset release so a byte
  // strobed on that edge is dropped rather than half-processed.
  assign kv = key_valid & armed_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    err_next   = 1'b0;
    if (kv) begin
      // A byte always wins over a coinciding timeout.
      cnt_next   = '0;
      state_next = ST_IDLE;
      unique case (state_reg)
        ST_IDLE: begin
          if (key_data == SC_E0)                               state_next = ST_GOT_E0;
          else if (key_data == SC_F0)                          state_next = ST_GOT_F0;
          else if (key_data == SC_NUL || key_data == SC_ERR)   err_next   = 1'b1;
          else                                                 emit       = 1'b1;
        end
        ST_GOT_E0: begin
          if (key_data == SC_F0)      state_next = ST_GOT_E0F0;
          else if (key_data == SC_E0) state_next = ST_GOT_E0;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        ST_GOT_F0: begin
          if (is_prefix(key_data)) err_next = 1'b1;
          else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
          end
        end
        ST_GOT_E0F0: begin
          if (is_prefix(key_data)) err_next = 1'b1;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (state_reg != ST_IDLE) begin
      if (cnt_reg == CNT_LAST) begin
        state_next = ST_IDLE;
        err_next   = 1'b1;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end else begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      armed_reg <= 1'b0;
      evt_valid <= 1'b0;
      evt_code  <= 8'h00;
      evt_ext   <= 1'b0;
      evt_break <= 1'b0;
      proto_err <= 1'b0;
      p1_up     <= 1'b0;
      p1_down   <= 1'b0;
      p2_up     <= 1'b0;
      p2_down   <= 1'b0;
      start_key <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      armed_reg <= 1'b1;
      evt_valid <= emit;
      proto_err <= err_next;
      if (emit) begin
        evt_code  <= key_data;
        evt_ext   <= emit_ext;
        evt_break <= emit_brk;
        // The E0 flag is part of the key identity: E0 1D is not W.
        case ({emit_ext, key_data})
          {1'b0, SC_W}:     p1_up     <= ~emit_brk;
          {1'b0, SC_S}:     p1_down   <= ~emit_brk;
          {1'b1, SC_UP}:    p2_up     <= ~emit_brk;
          {1'b1, SC_DOWN}:  p2_down   <= ~emit_brk;
          {1'b0, SC_SPACE}: start_key <= ~emit_brk;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
module tb_ps2_keycode_decoder;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       evt_valid, evt_ext, evt_break, proto_err;
  logic [7:0] evt_code;
  logic       p1_up, p1_down, p2_up, p2_down, start_key;

  ps2_keycode_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_data(key_data),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext),
    .evt_break(evt_break), .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up),
    .p2_down(p2_down), .start_key(start_key), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Snapshot layout: {valid, err, code[7:0], ext, brk, levels[4:0]}
  // levels = {start_key, p2_down, p2_up, p1_down, p1_up}
  function automatic logic [16:0] snap();
    return {evt_valid, proto_err, evt_code, evt_ext, evt_break,
            start_key, p2_down, p2_up, p1_down, p1_up};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Drive one cycle; when key_valid is low the data bus carries junk.
  task automatic step(input logic kv, input logic [7:0] kd);
    key_valid = kv;
    key_data  = kv ? kd : 8'($urandom);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  typedef struct {
    logic        kv;
    logic [7:0]  kd;
    logic [16:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  c_code = 8'h00;
  logic        c_ext = 1'b0, c_brk = 1'b0;
  logic [4:0]  c_lv = 5'b0;

  function automatic void ev(input logic [7:0] kd, input logic ext, input logic brk, input logic [4:0] lv);
    c_code = kd; c_ext = ext; c_brk = brk; c_lv = lv;
    tbl.push_back('{1'b1, kd, {1'b1, 1'b0, kd, ext, brk, lv}});
  endfunction
  function automatic void nx(input logic [7:0] kd);
    tbl.push_back('{1'b1, kd, {1'b0, 1'b0, c_code, c_ext, c_brk, c_lv}});
  endfunction
  function automatic void er(input logic [7:0] kd);
    tbl.push_back('{1'b1, kd, {1'b0, 1'b1, c_code, c_ext, c_brk, c_lv}});
  endfunction
  function automatic void idle();
    tbl.push_back('{1'b0, 8'h00, {1'b0, 1'b0, c_code, c_ext, c_brk, c_lv}});
  endfunction

  // Reference model: pending-prefix flags plus a silence counter.
  logic       m_ext_pend, m_brk_pend, m_valid, m_err, m_ext, m_brk;
  logic [7:0] m_code;
  logic [4:0] m_lv;
  int         m_silence;

  function automatic void m_event(input logic [7:0] kd, input logic ext, input logic brk);
    m_valid = 1'b1; m_code = kd; m_ext = ext; m_brk = brk;
    if (!ext && kd == 8'h1D) m_lv[0] = !brk;
    if (!ext && kd == 8'h1B) m_lv[1] = !brk;
    if ( ext && kd == 8'h75) m_lv[2] = !brk;
    if ( ext && kd == 8'h72) m_lv[3] = !brk;
    if (!ext && kd == 8'h29) m_lv[4] = !brk;
  endfunction

  function automatic void m_cycle(input logic kv, input logic [7:0] kd);
    m_valid = 1'b0; m_err = 1'b0;
    if (kv) begin
      m_silence = 0;
      if (kd == 8'hE0 && !m_brk_pend) m_ext_pend = 1'b1;
      else if (kd == 8'hF0 && !m_brk_pend) m_brk_pend = 1'b1;
      else if (m_brk_pend && (kd == 8'hE0 || kd == 8'hF0)) begin
        m_err = 1'b1; m_ext_pend = 1'b0; m_brk_pend = 1'b0;
      end else if (!m_ext_pend && !m_brk_pend && (kd == 8'h00 || kd == 8'hFF)) begin
        m_err = 1'b1;
      end else begin
        m_event(kd, m_ext_pend, m_brk_pend);
        m_ext_pend = 1'b0; m_brk_pend = 1'b0;
      end
    end else if (m_ext_pend || m_brk_pend) begin
      m_silence++;
      if (m_silence == T) begin
        m_err = 1'b1; m_ext_pend = 1'b0; m_brk_pend = 1'b0; m_silence = 0;
      end
    end
  endfunction

  initial begin
    logic [7:0] picks[10];
    logic       kv;
    logic [7:0] kd;
    int         gap;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(snap()), 32'h0);
    rst_n = 1'b1;
    step(1'b0, 8'h00);  // arming edge

    // ---------------- table-driven vectors ----------------
    ev(8'h1D, 0, 0, 5'b00001); idle(); nx(8'hF0); ev(8'h1D, 0, 1, 5'b00000);
    nx(8'hE0); ev(8'h75, 1, 0, 5'b00100); idle();
    nx(8'hE0); nx(8'hF0); ev(8'h75, 1, 1, 5'b00000);
    ev(8'h1D, 0, 0, 5'b00001); nx(8'hE0); ev(8'h72, 1, 0, 5'b01001);
    nx(8'hF0); ev(8'h1D, 0, 1, 5'b01000);
    nx(8'hF0); er(8'hF0); er(8'h00); ev(8'h5A, 0, 0, 5'b01000);
    nx(8'hE0); ev(8'h1D, 1, 0, 5'b01000);
    nx(8'hE0); nx(8'hE0); ev(8'h72, 1, 0, 5'b01000);
    nx(8'hE0); nx(8'hF0); ev(8'h72, 1, 1, 5'b00000);
    er(8'hFF); ev(8'h29, 0, 0, 5'b10000); nx(8'hF0); ev(8'h29, 0, 1, 5'b00000);
    ev(8'h1B, 0, 0, 5'b00010); nx(8'hF0); ev(8'h1B, 0, 1, 5'b00000);
    nx(8'hE0); nx(8'hF0); er(8'hE0); idle();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].kv, tbl[i].kd);
      check($sformatf("vec%0d kv=%0b kd=%h", i, tbl[i].kv, tbl[i].kd),
            32'(snap()), 32'(tbl[i].exp));
    end

    // ---------------- timeout after E0 ----------------
    step(1'b1, 8'hE0);
    for (int i = 1; i <= T; i++) begin
      step(1'b0, 8'h00);
      check($sformatf("timeout idle%0d err/valid", i), {proto_err, evt_valid},
            {(i == T), 1'b0});
    end
    step(1'b0, 8'h00);
    check("timeout err single pulse", proto_err, 1'b0);
    step(1'b1, 8'h1D);
    check("after timeout press", {evt_valid, proto_err, evt_code, evt_ext, evt_break, p1_up},
          {1'b1, 1'b0, 8'h1D, 1'b0, 1'b0, 1'b1});
    step(1'b1, 8'hF0); step(1'b1, 8'h1D);
    check("after timeout release", {evt_valid, p1_up}, 2'b10);

    // ---------------- byte coinciding with expiry ----------------
    step(1'b1, 8'hE0);
    repeat (T - 1) step(1'b0, 8'h00);
    step(1'b1, 8'h75);
    check("coincide byte wins", {evt_valid, proto_err, evt_code, evt_ext, p2_up},
          {1'b1, 1'b0, 8'h75, 1'b1, 1'b1});
    step(1'b1, 8'hE0); step(1'b1, 8'hF0); step(1'b1, 8'h75);
    check("coincide release", {evt_valid, evt_break, p2_up}, 3'b110);

    // ---------------- reset mid-sequence ----------------
    step(1'b1, 8'h1D);
    step(1'b1, 8'hE0); step(1'b1, 8'hF0);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'(snap()), 32'h0);
    @(posedge clk); #1;
    check("held reset outputs", 32'(snap()), 32'h0);
    rst_n = 1'b1;
    step(1'b1, 8'h1D);  // lands on the release edge: dropped
    check("release edge ignored", 32'(snap()), 32'h0);
    step(1'b1, 8'h75);
    check("post reset 75 plain", 32'(snap()),
          32'({1'b1, 1'b0, 8'h75, 1'b0, 1'b0, 5'b00000}));

    // ---------------- randomized vs model ----------------
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 8'h00);
    m_ext_pend = 0; m_brk_pend = 0; m_valid = 0; m_err = 0;
    m_ext = 0; m_brk = 0; m_code = 8'h00; m_lv = 5'b0; m_silence = 0;
    picks = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29, 8'h00, 8'hFF, 8'h5A};
    gap = 0;
    for (int c = 0; c < 3000; c++) begin
      if (gap > 0) begin
        kv = 1'b0; gap--;
      end else begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 3) gap = $urandom_range(10, 25);
        kv = (r >= 50);
      end
      kd = picks[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) kd = 8'($urandom);
      m_cycle(kv, kd);
      step(kv, kd);
      if (snap() !== {m_valid, m_err, m_code, m_ext, m_brk, m_lv} || c % 250 == 0)
        check($sformatf("rand c%0d kv=%0b kd=%h", c, kv, kd), 32'(snap()),
              32'({m_valid, m_err, m_code, m_ext, m_brk, m_lv}));
      else
        n_cmp++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
